// File: rtl/phy_serializer_tx_pkg.sv
// Shared types and constants for the PHY serial transmitter.
package phy_pkg;

    // Link bring-up state: TRAIN sends only idle words, ACTIVE accepts data.
    typedef enum logic [0:0] {
        TRAIN  = 1'b0,
        ACTIVE = 1'b1
    } phy_state_e;

    // K28.5-style comma pattern used for training and idle fill.
    localparam logic [7:0] IDLE_WORD_DEFAULT = 8'hBC;

endpackage

// File: rtl/phy_serializer_tx_if.sv
// Parallel-in handshake plus serial-out bus of the PHY transmitter.
interface phy_serializer_tx_if #(
    parameter int WIDTH = 8
) ();
    logic [WIDTH-1:0] data_in;
    logic             valid_in;
    logic             ready_out;
    logic             data_out;
    logic             frame_out;
    logic             active_out;

    // Word source side (drives data, observes the serial stream).
    modport master (
        output data_in,
        output valid_in,
        input  ready_out,
        input  data_out,
        input  frame_out,
        input  active_out
    );

    // Transmitter side.
    modport slave (
        input  data_in,
        input  valid_in,
        output ready_out,
        output data_out,
        output frame_out,
        output active_out
    );
endinterface

// File: rtl/phy_serializer_tx_piso_shift_reg.sv
// Parallel-in serial-out shift register; the first bit of a loaded word
// appears on data_out in the cycle directly after the load edge.
module piso_shift_reg #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk_32f,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_word,
    output logic             data_out
);
    logic [WIDTH-1:0] shift_r;
    logic             data_r;

    // Load a fresh word at a boundary, otherwise present the next queued bit.
    always_ff @(posedge clk_32f) begin
        if (reset) begin
            shift_r <= {WIDTH{1'b0}};
            data_r  <= 1'b0;
        end else if (load) begin
            if (MSB_FIRST) begin
                data_r  <= load_word[WIDTH-1];
                shift_r <= {load_word[WIDTH-2:0], 1'b0};
            end else begin
                data_r  <= load_word[0];
                shift_r <= {1'b0, load_word[WIDTH-1:1]};
            end
        end else begin
            if (MSB_FIRST) begin
                data_r  <= shift_r[WIDTH-1];
                shift_r <= {shift_r[WIDTH-2:0], 1'b0};
            end else begin
                data_r  <= shift_r[0];
                shift_r <= {1'b0, shift_r[WIDTH-1:1]};
            end
        end
    end

    assign data_out = data_r;

endmodule

// File: rtl/phy_serializer_tx.sv
// PHY serial transmitter: trains the link with idle words after reset, then
// serialises accepted parallel words with idle fill when no data is offered.
module phy_serializer_tx
    import phy_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] IDLE_WORD   = WIDTH'(IDLE_WORD_DEFAULT),
    parameter int               TRAIN_WORDS = 4,
    parameter bit               MSB_FIRST   = 1'b1
) (
    input  logic               clk_32f,
    input  logic               reset,
    phy_serializer_tx_if.slave bus
);
    localparam int                CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0]  PRE_LAST = CNT_W'(WIDTH - 2);
    localparam logic [7:0]        LAST_TRN = 8'(TRAIN_WORDS - 1);

    phy_state_e       state_r;
    logic [CNT_W-1:0] bit_cnt_r;
    logic [7:0]       word_cnt_r;
    logic             ready_r;
    logic             frame_r;

    logic             boundary_s;
    logic             take_s;
    logic [WIDTH-1:0] load_word_s;

    // Word boundary detect and load-word selection (data only on a handshake).
    always_comb begin
        boundary_s  = (bit_cnt_r == LAST_BIT);
        take_s      = ready_r & bus.valid_in;
        load_word_s = IDLE_WORD;
        if (take_s) begin
            load_word_s = bus.data_in;
        end else begin
            load_word_s = IDLE_WORD;
        end
    end

    // Bit counter, training FSM and registered handshake/frame outputs.
    always_ff @(posedge clk_32f) begin
        if (reset) begin
            state_r    <= TRAIN;
            bit_cnt_r  <= LAST_BIT;
            word_cnt_r <= 8'd0;
            ready_r    <= 1'b0;
            frame_r    <= 1'b0;
        end else begin
            frame_r <= boundary_s;
            if (boundary_s) begin
                bit_cnt_r <= {CNT_W{1'b0}};
            end else begin
                bit_cnt_r <= bit_cnt_r + CNT_W'(1);
            end
            case (state_r)
                TRAIN: begin
                    // Leaving TRAIN restarts bit_cnt at 0, so ready stays low here.
                    ready_r <= 1'b0;
                    if (boundary_s) begin
                        word_cnt_r <= word_cnt_r + 8'd1;
                        if (word_cnt_r == LAST_TRN) begin
                            state_r <= ACTIVE;
                        end
                    end
                end
                ACTIVE: begin
                    // Ready in the cycle whose closing edge is the next boundary.
                    ready_r <= (bit_cnt_r == PRE_LAST);
                end
                default: begin
                    state_r <= TRAIN;
                    ready_r <= 1'b0;
                end
            endcase
        end
    end

    piso_shift_reg #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_piso (
        .clk_32f   (clk_32f),
        .reset     (reset),
        .load      (boundary_s),
        .load_word (load_word_s),
        .data_out  (bus.data_out)
    );

    assign bus.ready_out  = ready_r;
    assign bus.frame_out  = frame_r;
    assign bus.active_out = (state_r == ACTIVE);

endmodule
